piso_shift_ctrl: RTL and testbench

Word-to-serial transmit controller that owns a WIDTH-bit parallel-in/serial-out shift register and sequences it.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out MSB first at a programmable bit period of DIV clocks.
- Marks the frame, the bit sample points and word completion.
- Sits between a word producer and a serial pin/link; supports zero-gap back-to-back words and a pause input.

---
 rtl/piso_shift_ctrl.sv | 157 +++++++++++++++
 tb/tb_piso_shift_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_ctrl.sv
// -----------------------------------------------------------------------------
// piso_shift_ctrl
//
// Word-to-serial transmit controller. Owns a WIDTH-bit parallel-in/serial-out
// shift register and sequences it: a word is taken from the producer over a
// valid/ready handshake, then shifted out MSB first with each bit held for DIV
// clocks. Words can follow each other with no idle gap, and shifting can be
// frozen at any time with the pause input.
//
// Ports
//   clock      : system clock, all state changes on the rising edge
//   clear      : synchronous active-high reset, overrides every other input
//   in_data    : parallel word offered by the producer
//   in_valid   : producer has a word on in_data
//   in_ready   : a word is taken this cycle when in_valid is also high
//   pause      : freezes the bit timer, bit counter and shift register
//   ser_out    : serial data (MSB of the shift register), 0 when idle
//   ser_frame  : high for every cycle a word is being shifted
//   ser_strobe : high in the last clock of each bit period (sample point)
//   done       : one-cycle pulse in the cycle after the last bit of a word ends
//   busy_bit   : index of the bit on ser_out (0 = MSB), 0 when idle
// -----------------------------------------------------------------------------
module piso_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 2
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     pause,
    output logic                     ser_out,
    output logic                     ser_frame,
    output logic                     ser_strobe,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] busy_bit
);

    // The bit timer still needs one flop when DIV is 1, even though it then
    // never leaves zero.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   sreg_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_cnt_next;
    logic               done_next;

    logic               shifting;
    logic               bit_end;
    logic               word_end;
    logic               transfer;

    // Timing decodes shared by the handshake, the outputs and the next-state
    // logic. bit_end is the sample point of the current bit; word_end is the
    // sample point of the final bit, the only cycle in SHIFT where a new word
    // may be taken so that streaming needs no idle gap. Pause masks both, so
    // a paused last bit neither completes nor opens the handshake.
    always_comb begin
        shifting = (state == SHIFT);
        bit_end  = shifting && !pause && (div_cnt == DIV_LAST);
        word_end = bit_end && (bit_cnt == BIT_LAST);
        in_ready = (state == IDLE) || word_end;
        transfer = in_valid && in_ready;
    end

    // Serial-side outputs. ser_out is gated by the frame as well as being
    // zeroed in the register on the way to IDLE, so the pin is quiet in idle
    // regardless of how the controller got there.
    always_comb begin
        ser_frame  = shifting;
        ser_out    = shifting && sreg[WIDTH-1];
        ser_strobe = bit_end;
        busy_bit   = shifting ? bit_cnt : '0;
    end

    // Next-state logic. Everything holds by default, which also gives the
    // pause behaviour in SHIFT for free. A new word always restarts both
    // counters, whether it arrives from IDLE or back-to-back at word_end.
    always_comb begin
        state_next   = state;
        sreg_next    = sreg;
        bit_cnt_next = bit_cnt;
        div_cnt_next = div_cnt;
        done_next    = word_end;

        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next   = SHIFT;
                    sreg_next    = in_data;
                    bit_cnt_next = '0;
                    div_cnt_next = '0;
                end
            end

            SHIFT: begin
                if (!pause) begin
                    if (word_end) begin
                        bit_cnt_next = '0;
                        div_cnt_next = '0;
                        if (transfer) begin
                            sreg_next = in_data;
                        end else begin
                            state_next = IDLE;
                            sreg_next  = '0;
                        end
                    end else if (bit_end) begin
                        sreg_next    = {sreg[WIDTH-2:0], 1'b0};
                        bit_cnt_next = bit_cnt + 1'b1;
                        div_cnt_next = '0;
                    end else begin
                        div_cnt_next = div_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                sreg_next  = '0;
            end
        endcase
    end

    // State register. clear abandons any word in flight without a done
    // pulse; the bits already sent are simply lost.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            sreg    <= sreg_next;
            bit_cnt <= bit_cnt_next;
            div_cnt <= div_cnt_next;
            done    <= done_next;
        end
    end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_ctrl
//
// Drives two controllers (DIV=2 and DIV=1, both WIDTH=4) from the same
// producer inputs. Each has a cycle-level reference model built on a single
// phase counter, plus a scoreboard: accepted words are queued at the handshake
// and compared against the bits collected from ser_out at each strobe when
// the controller raises done.
// -----------------------------------------------------------------------------
module tb_piso_shift_ctrl;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       pause = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'b0000;
    bit         checking = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive the shared inputs and hold them for n rising edges.
    task automatic applyStimulus(input logic v, input logic [3:0] d,
                                 input logic p, input logic c, input int n);
        in_valid = v;
        in_data  = d;
        pause    = p;
        clear    = c;
        repeat (n) @(posedge clock);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int DV = (g == 0) ? 2 : 1;
        localparam int W  = 4;

        logic       d_ready;
        logic       d_out;
        logic       d_frame;
        logic       d_strobe;
        logic       d_done;
        logic [1:0] d_busy;

        piso_shift_ctrl #(.WIDTH(W), .DIV(DV)) dut (
            .clock      (clock),
            .clear      (clear),
            .in_data    (in_data),
            .in_valid   (in_valid),
            .in_ready   (d_ready),
            .pause      (pause),
            .ser_out    (d_out),
            .ser_frame  (d_frame),
            .ser_strobe (d_strobe),
            .done       (d_done),
            .busy_bit   (d_busy)
        );

        // Reference model: m_phase counts unpaused cycles since the word began.
        logic         m_active = 1'b0;
        logic [W-1:0] m_word   = '0;
        int           m_phase  = 0;
        logic         m_done   = 1'b0;
        logic         m_flush  = 1'b0;
        int           m_idx;
        logic         m_strobe;
        logic         m_last;
        logic         m_ready;
        logic         m_out;

        always_comb begin
            m_idx    = m_phase / DV;
            m_strobe = m_active && !pause && ((m_phase % DV) == DV - 1);
            m_last   = m_strobe && (m_phase == W * DV - 1);
            m_ready  = !m_active || m_last;
            m_out    = m_active ? m_word[W - 1 - m_idx] : 1'b0;
        end

        logic [W-1:0] sb[$];
        logic [W-1:0] cap   = '0;
        int           cap_n = 0;
        logic [W-1:0] exp_word;

        always @(posedge clock) begin
            m_flush <= clear;
            if (clear) begin
                m_active <= 1'b0;
                m_phase  <= 0;
                m_done   <= 1'b0;
            end else begin
                m_done <= m_last;
                if (in_valid && m_ready) begin
                    m_active <= 1'b1;
                    m_word   <= in_data;
                    m_phase  <= 0;
                    sb.push_back(in_data);
                end else if (m_last) begin
                    m_active <= 1'b0;
                    m_phase  <= 0;
                end else if (m_active && !pause) begin
                    m_phase <= m_phase + 1;
                end
            end
        end

        always @(negedge clock) begin
            if (m_flush) begin
                sb.delete();
                cap   = '0;
                cap_n = 0;
            end
            if (checking) begin
                checkOutput($sformatf("i%0d in_ready", g), 32'(d_ready), 32'(m_ready));
                checkOutput($sformatf("i%0d ser_out", g), 32'(d_out), 32'(m_out));
                checkOutput($sformatf("i%0d ser_frame", g), 32'(d_frame), 32'(m_active));
                checkOutput($sformatf("i%0d ser_strobe", g), 32'(d_strobe), 32'(m_strobe));
                checkOutput($sformatf("i%0d done", g), 32'(d_done), 32'(m_done));
                checkOutput($sformatf("i%0d busy_bit", g), 32'(d_busy),
                            32'(m_active ? m_idx : 0));
                if (d_done === 1'b1) begin
                    exp_word = (sb.size() > 0) ? sb.pop_front() : ~cap;
                    checkOutput($sformatf("i%0d word", g), 32'(cap), 32'(exp_word));
                    checkOutput($sformatf("i%0d bitcount", g), 32'(cap_n), 32'(W));
                    cap   = '0;
                    cap_n = 0;
                end
                if (d_strobe === 1'b1) begin
                    cap   = {cap[W-2:0], d_out};
                    cap_n = cap_n + 1;
                end
            end
        end
    end

    initial begin
        // Reset, then check the reset state while idling.
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2);
        checking = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 3);

        // Single word.
        applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 12);

        // Back-to-back: second word offered at the first word's last strobe.
        applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0, 8);
        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 20);

        // Pause in the middle of a word.
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 12);

        // Reset mid-word, then a fresh word right after.
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 12);

        // Streaming with valid held.
        applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 12);

        // Pause while idle, then a word offered during pause.
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 10);
        applyStimulus(1'b1, 4'b1101, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 12);

        // Pause landing on the last-bit strobe with the next word waiting.
        applyStimulus(1'b1, 4'b1100, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 7);
        applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0, 2);
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 12);

        // Random traffic with occasional pause and reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0), 4'($urandom),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 59) == 0), 1);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
